// File: rtl/fsm_sequence_decoder_if.sv
// Sample, decoded-bit and packed-word signals of the sequence decoder.
// master drives samples and data_ready; slave is the decoder.
interface fsm_sequence_decoder_if #(
    parameter int WORD_W = 8
);
    logic              in_valid;
    logic              y1;
    logic              y2;
    logic              bit_out;
    logic              bit_valid;
    logic [WORD_W-1:0] data;
    logic              data_valid;
    logic              data_ready;
    logic              sync_err;
    logic              overflow;

    modport master (
        output in_valid, y1, y2, data_ready,
        input  bit_out, bit_valid, data,
        input  data_valid, sync_err, overflow
    );

    modport slave (
        input  in_valid, y1, y2, data_ready,
        output bit_out, bit_valid, data,
        output data_valid, sync_err, overflow
    );
endinterface

// File: rtl/fsm_sequence_decoder.sv
// Recovers the x input of a 3-state source FSM from its observed
// state codes and packs the recovered bits into WORD_W-bit words.
module fsm_sequence_decoder #(
    parameter int WORD_W = 8
) (
    input logic clk,
    input logic reset,
    fsm_sequence_decoder_if.slave bus
);
    localparam int CW = $clog2(WORD_W);
    localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

    typedef enum logic {
        SYNC,
        TRACK
    } state_t;

    state_t            state;
    logic [1:0]        prev;
    logic [CW-1:0]     cnt;
    logic [WORD_W-1:0] sreg;

    logic [1:0]        code;
    logic [1:0]        fwd;
    logic              illegal;
    logic              stall;
    logic              is_fwd;
    logic              last;
    logic [WORD_W-1:0] word_n;

    assign code = {bus.y1, bus.y2};

    // Codes {y1,y2}: S0=00, S1=10, S2=01; fwd is the x=1 successor.
    always_comb begin
        fwd = 2'b00;
        case (prev)
            2'b00:   fwd = 2'b10;
            2'b10:   fwd = 2'b01;
            default: fwd = 2'b00;
        endcase
    end

    always_comb begin
        illegal     = (code == 2'b11);
        stall       = illegal || (code == prev);
        is_fwd      = (code == fwd);
        last        = (cnt == LAST);
        word_n      = sreg;
        word_n[cnt] = is_fwd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= TRACK;
            prev           <= 2'b00;
            cnt            <= '0;
            sreg           <= '0;
            bus.bit_out    <= 1'b0;
            bus.bit_valid  <= 1'b0;
            bus.data       <= '0;
            bus.data_valid <= 1'b0;
            bus.sync_err   <= 1'b0;
            bus.overflow   <= 1'b0;
        end else begin
            bus.bit_valid <= 1'b0;
            bus.sync_err  <= 1'b0;
            bus.overflow  <= 1'b0;
            if (bus.data_valid && bus.data_ready) begin
                bus.data_valid <= 1'b0;
            end
            if (bus.in_valid) begin
                case (state)
                    TRACK: begin
                        if (stall) begin
                            bus.sync_err <= 1'b1;
                            cnt          <= '0;
                            state        <= SYNC;
                        end else begin
                            bus.bit_out   <= is_fwd;
                            bus.bit_valid <= 1'b1;
                            prev          <= code;
                            sreg          <= word_n;
                            if (last) begin
                                cnt <= '0;
                                // A word may replace one leaving this cycle.
                                if (!bus.data_valid
                                    || bus.data_ready) begin
                                    bus.data       <= word_n;
                                    bus.data_valid <= 1'b1;
                                end else begin
                                    bus.overflow <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (illegal) begin
                            bus.sync_err <= 1'b1;
                        end else begin
                            prev  <= code;
                            state <= TRACK;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fsm_sequence_decoder.sv
// Directed vector table, hand-written reset sequence and a random run
// checked against a mod-3 position model of the source FSM.
module tb_fsm_sequence_decoder;
    localparam int W = 8;

    logic clk;
    logic reset;

    fsm_sequence_decoder_if #(.WORD_W(W)) bus ();

    fsm_sequence_decoder #(.WORD_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [1:0] code;
        logic       rdy;
        logic       bv;
        logic       bo;
        logic       dv;
        logic [7:0] data;
        logic       se;
        logic       ov;
    } vec_t;

    vec_t tbl[$];
    int n_chk;
    int n_fail;

    // model state
    logic   m_track;
    int     m_pos;
    logic   m_q[$];
    logic   e_bo, e_bv, e_dv, e_se, e_ov;
    logic [7:0] e_data;

    logic [1:0] a5c [8];
    logic [1:0] onec [8];
    logic [1:0] zeroc [8];
    logic [7:0] a5w;

    function automatic void add(
        logic iv, logic [1:0] code, logic rdy,
        logic bv, logic bo, logic dv,
        logic [7:0] data, logic se, logic ov);
        vec_t v;
        v.iv = iv; v.code = code; v.rdy = rdy;
        v.bv = bv; v.bo = bo; v.dv = dv;
        v.data = data; v.se = se; v.ov = ov;
        tbl.push_back(v);
    endfunction

    task automatic chk(string n, logic [31:0] act,
                       logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     n, act, exp);
        end
    endtask

    task automatic drive(logic iv, logic [1:0] c, logic rdy);
        bus.in_valid   = iv;
        bus.y1         = c[1];
        bus.y2         = c[0];
        bus.data_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(string n);
        chk({n, " bit_out"}, 32'(bus.bit_out), 0);
        chk({n, " bit_valid"}, 32'(bus.bit_valid), 0);
        chk({n, " data"}, 32'(bus.data), 0);
        chk({n, " data_valid"}, 32'(bus.data_valid), 0);
        chk({n, " sync_err"}, 32'(bus.sync_err), 0);
        chk({n, " overflow"}, 32'(bus.overflow), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        m_track = 1'b1;
        m_pos   = 0;
        m_q.delete();
        e_bo = 0; e_bv = 0; e_dv = 0;
        e_se = 0; e_ov = 0; e_data = '0;
        reset = 1'b1;
    endtask

    function automatic int code2idx(logic [1:0] c);
        case (c)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b01:   return 2;
            default: return -1;
        endcase
    endfunction

    function automatic logic [1:0] idx2code(int i);
        case (i)
            0:       return 2'b00;
            1:       return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    function automatic void model(logic iv, logic [1:0] c,
                                  logic rdy);
        logic dv0;
        logic b;
        int   idx;
        logic [7:0] w;
        dv0  = e_dv;
        e_bv = 0; e_se = 0; e_ov = 0;
        if (dv0 && rdy) e_dv = 0;
        if (!iv) return;
        idx = code2idx(c);
        if (!m_track) begin
            if (idx < 0) begin
                e_se = 1;
            end else begin
                m_pos   = idx;
                m_track = 1;
            end
            return;
        end
        if (idx < 0 || idx == m_pos) begin
            e_se = 1;
            m_q.delete();
            m_track = 0;
            return;
        end
        b     = ((idx - m_pos + 3) % 3 == 1);
        e_bo  = b;
        e_bv  = 1;
        m_pos = idx;
        m_q.push_back(b);
        if (m_q.size() == W) begin
            w = '0;
            for (int i = 0; i < W; i++) w[i] = m_q[i];
            m_q.delete();
            if (!dv0 || rdy) begin
                e_data = w;
                e_dv   = 1;
            end else begin
                e_ov = 1;
            end
        end
    endfunction

    initial begin
        vec_t v;
        string s;
        int   r;
        logic [1:0] c;
        logic iv, rdy;
        n_chk  = 0;
        n_fail = 0;
        a5w    = 8'hA5;
        a5c    = '{2'b10, 2'b00, 2'b10, 2'b00,
                   2'b01, 2'b00, 2'b01, 2'b00};
        onec   = '{2'b01, 2'b00, 2'b10, 2'b01,
                   2'b00, 2'b10, 2'b01, 2'b00};
        zeroc  = '{2'b01, 2'b10, 2'b00, 2'b01,
                   2'b10, 2'b00, 2'b01, 2'b10};

        // first word 0xA5, then an overflowing second word
        for (int i = 0; i < 8; i++)
            add(1, a5c[i], 0, 1, a5w[i], i == 7, 8'hA5, 0, 0);
        for (int i = 0; i < 8; i++)
            add(1, a5c[i], 0, 1, a5w[i], 1, 8'hA5, 0, i == 7);
        add(0, 2'b00, 1, 0, 0, 0, 8'h00, 0, 0);
        // illegal code mid-word, resync, then repeated code
        add(1, 2'b10, 0, 1, 1, 0, 8'h00, 0, 0);
        add(1, 2'b00, 0, 1, 0, 0, 8'h00, 0, 0);
        add(1, 2'b10, 0, 1, 1, 0, 8'h00, 0, 0);
        add(1, 2'b11, 0, 0, 0, 0, 8'h00, 1, 0);
        add(1, 2'b10, 0, 0, 0, 0, 8'h00, 0, 0);
        add(1, 2'b00, 0, 1, 0, 0, 8'h00, 0, 0);
        add(1, 2'b00, 0, 0, 0, 0, 8'h00, 1, 0);
        add(0, 2'b11, 1, 0, 0, 0, 8'h00, 0, 0);
        add(1, 2'b11, 0, 0, 0, 0, 8'h00, 1, 0);
        add(1, 2'b10, 0, 0, 0, 0, 8'h00, 0, 0);
        // 0xFF, then 0x00 completing on a handshake
        for (int i = 0; i < 8; i++)
            add(1, onec[i], 0, 1, 1, i == 7, 8'hFF, 0, 0);
        for (int i = 0; i < 8; i++)
            add(1, zeroc[i], i == 7, 1, 0, 1,
                i == 7 ? 8'h00 : 8'hFF, 0, 0);
        add(0, 2'b00, 1, 0, 0, 0, 8'h00, 0, 0);
        add(0, 2'b00, 1, 0, 0, 0, 8'h00, 0, 0);

        bus.in_valid   = 0;
        bus.y1         = 0;
        bus.y2         = 0;
        bus.data_ready = 0;
        reset          = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1;

        foreach (tbl[i]) begin
            v = tbl[i];
            drive(v.iv, v.code, v.rdy);
            s = $sformatf("vec%0d", i);
            chk({s, " bit_valid"}, 32'(bus.bit_valid), 32'(v.bv));
            if (v.bv)
                chk({s, " bit_out"}, 32'(bus.bit_out), 32'(v.bo));
            chk({s, " data_valid"}, 32'(bus.data_valid),
                32'(v.dv));
            if (v.dv)
                chk({s, " data"}, 32'(bus.data), 32'(v.data));
            chk({s, " sync_err"}, 32'(bus.sync_err), 32'(v.se));
            chk({s, " overflow"}, 32'(bus.overflow), 32'(v.ov));
        end

        // asynchronous reset mid-word with a word pending
        do_reset();
        for (int i = 0; i < 8; i++) drive(1, a5c[i], 0);
        chk("pre word", 32'(bus.data), 32'hA5);
        for (int i = 0; i < 5; i++) drive(1, a5c[i], 0);
        chk("pre bit_valid", 32'(bus.bit_valid), 1);
        #3;
        reset = 0;
        #1;
        chk_zero("async");
        #2;
        reset = 1;
        drive(0, 2'b00, 0);
        chk("idle bit_valid", 32'(bus.bit_valid), 0);
        for (int i = 0; i < 8; i++) begin
            drive(1, a5c[i], 0);
            chk($sformatf("fresh%0d bit", i),
                32'(bus.bit_out), 32'(a5w[i]));
            chk($sformatf("fresh%0d dv", i),
                32'(bus.data_valid), 32'(i == 7));
        end
        chk("fresh data", 32'(bus.data), 32'hA5);

        // random run against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            iv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            r   = $urandom_range(0, 19);
            if (r < 9)       c = idx2code((m_pos + 1) % 3);
            else if (r < 18) c = idx2code((m_pos + 2) % 3);
            else if (r == 18) c = 2'b11;
            else             c = idx2code(m_pos);
            drive(iv, c, rdy);
            model(iv, c, rdy);
            s = $sformatf("rnd%0d", n);
            chk({s, " bit_valid"}, 32'(bus.bit_valid), 32'(e_bv));
            if (e_bv)
                chk({s, " bit_out"}, 32'(bus.bit_out), 32'(e_bo));
            chk({s, " data_valid"}, 32'(bus.data_valid),
                32'(e_dv));
            if (e_dv)
                chk({s, " data"}, 32'(bus.data), 32'(e_data));
            chk({s, " sync_err"}, 32'(bus.sync_err), 32'(e_se));
            chk({s, " overflow"}, 32'(bus.overflow), 32'(e_ov));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
